// File: rtl/input_sync_filter_pkg.sv
// Shared defaults and button index names for the mouse input conditioner.
// No ports; imported by the interface, the debounce channel and the top.
package input_sync_pkg;

  localparam int CHANNELS_DEF = 3;
  localparam int STAGES_DEF   = 2;
  localparam int DEBOUNCE_DEF = 4;
  localparam int POS_W_DEF    = 12;
  localparam int STABLE_DEF   = 3;

  localparam int BTN_LEFT   = 0;
  localparam int BTN_RIGHT  = 1;
  localparam int BTN_MIDDLE = 2;

endpackage

// File: rtl/input_sync_filter_if.sv
// Bus between the mouse controller side and the input conditioner.
// Signals:
//   btn_in, xpos_in, ypos_in      raw asynchronous mouse signals
//   btn_out, btn_rise, btn_fall   debounced levels and one-cycle edge pulses
//   xpos_out, ypos_out, pos_valid committed position and its update pulse
// Modports: master = mouse side (drives raw inputs, observes results),
//           slave  = conditioner.
interface input_sync_filter_if
  import input_sync_pkg::*;
#(
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int POS_W    = POS_W_DEF
) ();

  logic [CHANNELS-1:0] btn_in;
  logic [POS_W-1:0]    xpos_in;
  logic [POS_W-1:0]    ypos_in;
  logic [CHANNELS-1:0] btn_out;
  logic [CHANNELS-1:0] btn_rise;
  logic [CHANNELS-1:0] btn_fall;
  logic [POS_W-1:0]    xpos_out;
  logic [POS_W-1:0]    ypos_out;
  logic                pos_valid;

  modport master (
    output btn_in, xpos_in, ypos_in,
    input  btn_out, btn_rise, btn_fall, xpos_out, ypos_out, pos_valid
  );

  modport slave (
    input  btn_in, xpos_in, ypos_in,
    output btn_out, btn_rise, btn_fall, xpos_out, ypos_out, pos_valid
  );

endinterface

// File: rtl/input_sync_filter_btn_debounce.sv
// One button channel: STAGES-deep synchronizer, debounce counter and
// registered rise/fall pulses.
// Ports:
//   clk100MHz  system clock
//   rst        synchronous active-low reset
//   din        raw asynchronous button
//   dout       debounced level
//   rise/fall  one-cycle pulses coincident with a dout change
module btn_debounce
  import input_sync_pkg::*;
#(
  parameter int STAGES   = STAGES_DEF,
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic clk100MHz,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  // DEBOUNCE = 1 would give a zero-width counter; keep one bit.
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE - 1);

  generate
    if (STAGES < 2)   begin : g_bad_stages   $error("btn_debounce: STAGES must be >= 2");   end
    if (DEBOUNCE < 1) begin : g_bad_debounce $error("btn_debounce: DEBOUNCE must be >= 1"); end
  endgenerate

  logic [STAGES-1:0] sync;
  logic [DW-1:0]     dcnt;
  logic              s;

  assign s = sync[STAGES-1];

  always_ff @(posedge clk100MHz) begin
    if (!rst) begin
      sync <= '0;
      dcnt <= '0;
      dout <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      rise <= 1'b0;
      fall <= 1'b0;
      if (s != dout) begin
        // DEBOUNCE consecutive disagreeing edges flip the level.
        if (dcnt == DLAST) begin
          dout <= s;
          dcnt <= '0;
          rise <= s;
          fall <= ~s;
        end else begin
          dcnt <= dcnt + 1'b1;
        end
      end else begin
        // Any single agreeing cycle restarts the filter.
        dcnt <= '0;
      end
    end
  end

endmodule

// File: rtl/input_sync_filter.sv
// Mouse input conditioner: per-channel synchronized and debounced buttons
// with edge pulses, plus a synchronized XY bus committed only after it has
// held steady for STABLE repeat samples.
// Ports:
//   clk100MHz  system clock, rising edge
//   rst        synchronous active-low reset
//   bus        input_sync_filter_if slave (raw inputs in, filtered outputs out)
module input_sync_filter
  import input_sync_pkg::*;
#(
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int STAGES   = STAGES_DEF,
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int POS_W    = POS_W_DEF,
  parameter int STABLE   = STABLE_DEF
) (
  input  logic               clk100MHz,
  input  logic               rst,
  input_sync_filter_if.slave bus
);

  localparam int PW = 2 * POS_W;
  localparam int SW = $clog2(STABLE + 1);
  localparam logic [SW-1:0] SFULL = SW'(STABLE);
  localparam logic [SW-1:0] SLAST = SW'(STABLE - 1);

  generate
    if (STAGES < 2)   begin : g_bad_stages   $error("input_sync_filter: STAGES must be >= 2");   end
    if (DEBOUNCE < 1) begin : g_bad_debounce $error("input_sync_filter: DEBOUNCE must be >= 1"); end
    if (STABLE < 1)   begin : g_bad_stable   $error("input_sync_filter: STABLE must be >= 1");   end
  endgenerate

  // ---------------- buttons ----------------
  logic [CHANNELS-1:0] btn_lvl, btn_r, btn_f;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_btn
    btn_debounce #(
      .STAGES   (STAGES),
      .DEBOUNCE (DEBOUNCE)
    ) u_btn (
      .clk100MHz (clk100MHz),
      .rst       (rst),
      .din       (bus.btn_in[i]),
      .dout      (btn_lvl[i]),
      .rise      (btn_r[i]),
      .fall      (btn_f[i])
    );
  end

  assign bus.btn_out  = btn_lvl;
  assign bus.btn_rise = btn_r;
  assign bus.btn_fall = btn_f;

  // ---------------- position ----------------
  logic [STAGES-1:0][PW-1:0] pchain;
  logic [PW-1:0]             sample, cand, committed;
  logic [SW-1:0]             scnt;
  logic                      pvld;

  assign sample = pchain[STAGES-1];

  always_ff @(posedge clk100MHz) begin
    if (!rst) begin
      pchain    <= '0;
      cand      <= '0;
      scnt      <= '0;
      committed <= '0;
      pvld      <= 1'b0;
    end else begin
      pchain <= {pchain[STAGES-2:0], {bus.xpos_in, bus.ypos_in}};
      pvld   <= 1'b0;
      if (sample != cand) begin
        // New candidate; torn multi-bit samples die here since they
        // never repeat long enough to reach the commit point.
        cand <= sample;
        scnt <= '0;
      end else if (scnt != SFULL) begin
        scnt <= scnt + 1'b1;
        // A stable value equal to what is already out is absorbed silently.
        if (scnt == SLAST && cand != committed) begin
          committed <= cand;
          pvld      <= 1'b1;
        end
      end
    end
  end

  assign bus.xpos_out  = committed[PW-1:POS_W];
  assign bus.ypos_out  = committed[POS_W-1:0];
  assign bus.pos_valid = pvld;

endmodule

// File: tb/tb_input_sync_filter.sv
module tb_input_sync_filter;
  import input_sync_pkg::*;

  logic clk100MHz = 1'b0;
  logic rst       = 1'b0;
  int   vectors   = 0;
  int   errors    = 0;
  int   cnt, first;
  int   cnt2, first2;

  always #5 clk100MHz = ~clk100MHz;

  input_sync_filter_if #(.CHANNELS(3), .POS_W(12)) bus ();

  input_sync_filter #(
    .CHANNELS (3),
    .STAGES   (2),
    .DEBOUNCE (4),
    .POS_W    (12),
    .STABLE   (3)
  ) dut (
    .clk100MHz (clk100MHz),
    .rst       (rst),
    .bus       (bus)
  );

  // Advance one edge; outputs are then sampled 1 ns after it.
  task automatic tick();
    @(posedge clk100MHz);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    bus.btn_in  = 3'b111;
    bus.xpos_in = 12'd500;
    bus.ypos_in = 12'd0;

    // ---- reset held 5 cycles with inputs active ----
    cnt = 0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (bus.btn_rise != 0 || bus.btn_fall != 0 || bus.pos_valid) cnt++;
    end
    chk("rst_btn_out",   32'(bus.btn_out),  0);
    chk("rst_xpos_out",  32'(bus.xpos_out), 0);
    chk("rst_ypos_out",  32'(bus.ypos_out), 0);
    chk("rst_no_pulses", 32'(cnt),          0);

    // ---- release: everything lands at edge 6 ----
    rst = 1'b1;
    cnt = 0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (bus.btn_out != 0 || bus.btn_rise != 0 || bus.pos_valid) cnt++;
    end
    chk("rel_quiet_e1_5", 32'(cnt), 0);
    tick();
    chk("rel_btn_out_e6",  32'(bus.btn_out),   32'h7);
    chk("rel_btn_rise_e6", 32'(bus.btn_rise),  32'h7);
    chk("rel_xpos_e6",     32'(bus.xpos_out),  500);
    chk("rel_pvld_e6",     32'(bus.pos_valid), 1);
    tick();
    chk("rel_rise_e7", 32'(bus.btn_rise),  0);
    chk("rel_pvld_e7", 32'(bus.pos_valid), 0);

    // ---- all buttons low, settle ----
    bus.btn_in = 3'b000;
    ticks(8);
    chk("settle_low", 32'(bus.btn_out), 0);

    // ---- left glitch: 3 cycles high is rejected ----
    bus.btn_in[BTN_LEFT] = 1'b1;
    cnt = 0;
    for (int e = 1; e <= 12; e++) begin
      if (e == 4) bus.btn_in[BTN_LEFT] = 1'b0;
      tick();
      if (bus.btn_rise[BTN_LEFT] || bus.btn_out[BTN_LEFT]) cnt++;
    end
    chk("glitch_rejected", 32'(cnt), 0);

    // ---- left held: one rise at edge 6 ----
    bus.btn_in[BTN_LEFT] = 1'b1;
    cnt = 0; first = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (bus.btn_rise[BTN_LEFT]) begin cnt++; if (first == 0) first = e; end
    end
    chk("left_rise_edge",  32'(first), 6);
    chk("left_rise_count", 32'(cnt),   1);
    chk("left_level",      32'(bus.btn_out), 32'h1);

    // ---- right rises then falls ----
    bus.btn_in = 3'b011;
    ticks(8);
    chk("right_high", 32'(bus.btn_out), 32'h3);
    bus.btn_in = 3'b001;
    cnt = 0; first = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (bus.btn_fall[BTN_RIGHT]) begin cnt++; if (first == 0) first = e; end
    end
    chk("right_fall_edge",  32'(first), 6);
    chk("right_fall_count", 32'(cnt),   1);
    chk("right_low",        32'(bus.btn_out), 32'h1);

    // ---- right falls while middle rises in the same cycle ----
    bus.btn_in = 3'b011;
    ticks(8);
    bus.btn_in = 3'b101;
    first = 0; first2 = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 6) begin
        chk("coinc_rise_e6", 32'(bus.btn_rise), 32'h4);
        chk("coinc_fall_e6", 32'(bus.btn_fall), 32'h2);
      end
      if (bus.btn_fall[BTN_RIGHT] && first == 0) first = e;
      if (bus.btn_rise[BTN_MIDDLE] && first2 == 0) first2 = e;
    end
    chk("coinc_fall_edge", 32'(first),  6);
    chk("coinc_rise_edge", 32'(first2), 6);
    chk("coinc_level",     32'(bus.btn_out), 32'h5);

    // ---- skewed bus 100 -> 101 -> 102 -> 103 ----
    bus.xpos_in = 12'd100;
    ticks(8);
    chk("skew_base", 32'(bus.xpos_out), 100);
    bus.xpos_in = 12'd101;
    cnt = 0;
    tick(); if (bus.pos_valid) cnt++;
    bus.xpos_in = 12'd102;
    tick(); if (bus.pos_valid) cnt++;
    bus.xpos_in = 12'd103;
    first = 0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (bus.pos_valid) begin cnt++; if (first == 0) first = e; end
    end
    chk("skew_one_pvld", 32'(cnt),          1);
    chk("skew_pvld_edge", 32'(first),       6);
    chk("skew_xpos",     32'(bus.xpos_out), 103);

    // ---- revisit: short excursion back to committed value ----
    bus.xpos_in = 12'd200;
    bus.ypos_in = 12'd300;
    ticks(8);
    chk("rev_x_base", 32'(bus.xpos_out), 200);
    chk("rev_y_base", 32'(bus.ypos_out), 300);
    bus.ypos_in = 12'd301;
    cnt = 0;
    for (int e = 1; e <= 14; e++) begin
      if (e == 3) bus.ypos_in = 12'd300;
      tick();
      if (bus.pos_valid) cnt++;
    end
    chk("rev_no_pvld", 32'(cnt),          0);
    chk("rev_x_hold",  32'(bus.xpos_out), 200);
    chk("rev_y_hold",  32'(bus.ypos_out), 300);

    // ---- reset at edge 4 of a pending commit ----
    bus.xpos_in = 12'd700;
    cnt = 0;
    for (int e = 1; e <= 4; e++) begin
      if (e == 4) rst = 1'b0;
      tick();
      if (bus.pos_valid) cnt++;
    end
    chk("midrst_no_pvld", 32'(cnt),          0);
    chk("midrst_xpos",    32'(bus.xpos_out), 0);
    chk("midrst_ypos",    32'(bus.ypos_out), 0);
    chk("midrst_btn",     32'(bus.btn_out),  0);
    rst = 1'b1;
    cnt = 0; first = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (bus.pos_valid) begin cnt++; if (first == 0) first = e; end
    end
    chk("midrst_pvld_edge",  32'(first),          6);
    chk("midrst_pvld_count", 32'(cnt),            1);
    chk("midrst_xpos_after", 32'(bus.xpos_out),   700);
    chk("midrst_ypos_after", 32'(bus.ypos_out),   300);
    chk("midrst_btn_after",  32'(bus.btn_out),    32'h5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/input_sync_filter.md
# input_sync_filter

Parametrised input conditioner that brings asynchronous mouse signals into the clk100MHz domain. It provides CHANNELS independent button lines, each with a multi-flop synchronizer, a debounce filter and rise/fall pulses. It also provides an XY position bus that is committed only after it has been stable for a programmable number of cycles, and it flags each new position with a valid pulse. It sits between the mouse controller outputs and the downstream pixel-clock handover, and replaces plain flop-chain resynchronisation.

## Interface
Parameters:
- CHANNELS, 3: number of button lines (left, right, middle).
- STAGES, 2: synchronizer flop depth; must be ≥ 2.
- DEBOUNCE, 4: consecutive disagreeing cycles required to flip a button; must be ≥ 1.
- POS_W, 12: width of each position coordinate.
- STABLE, 3: consecutive repeat samples required to commit a position; must be ≥ 1.

Ports:
- clk100MHz  in  1  system clock; all logic on rising edge.
- rst  in  1  reset: synchronous, active-low, on clk100MHz.
- btn_in  in  CHANNELS  asynchronous raw buttons.
- xpos_in  in  POS_W  asynchronous X position.
- ypos_in  in  POS_W  asynchronous Y position.
- btn_out  out  CHANNELS  debounced button levels.
- btn_rise  out  CHANNELS  one-cycle pulse when btn_out goes 0→1.
- btn_fall  out  CHANNELS  one-cycle pulse when btn_out goes 1→0.
- xpos_out  out  POS_W  committed X position.
- ypos_out  out  POS_W  committed Y position.
- pos_valid  out  1  one-cycle pulse when xpos_out/ypos_out change.

## Operation
- Reset (rst = 0): every register clears to 0 on the next edge, including sync chains, debounce counters, candidate register and stability counter. All outputs read 0 the cycle after. Reset asserted mid-filter aborts any pending commit, with no pulse.

Per button channel:
- Synchronizer: chain of STAGES flops. Its last stage is `s`.
- Debounce counter `dcnt`, width $clog2(DEBOUNCE).
- Each edge where `s` != btn_out:
  - if `dcnt` == DEBOUNCE-1: btn_out <= `s`, `dcnt` <= 0, and the matching rise or fall pulse is asserted for exactly that cycle;
  - otherwise `dcnt` increments.
- Each edge where `s` == btn_out: `dcnt` <= 0, so any single-cycle agreement restarts the filter.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses.

Position path:
- Synchronizer: {xpos_in, ypos_in} pass through a STAGES-deep 2·POS_W-bit flop chain, giving `sample`.
- `cand` register and `scnt` counter (0..STABLE, saturating).
- Each edge:
  - `sample` != `cand`: `cand` <= `sample`, `scnt` <= 0.
  - `sample` == `cand` and `scnt` < STABLE: `scnt` increments.
    - If `scnt` == STABLE-1 and `cand` != {xpos_out, ypos_out}: outputs <= `cand` and pos_valid = 1 for that cycle.
  - `scnt` == STABLE: hold. No re-commit and no further pulse.
- A stable value equal to the current outputs is absorbed silently, e.g. a glitch followed by a return to the old value.
- Multi-bit skew is tolerated: torn samples never persist for STABLE+1 cycles, so they are never committed.

## Timing
Latencies are counted in edges after the input change; edge 1 is the first capture.
- Button:
  - btn_out and its pulse update at edge STAGES + DEBOUNCE (default: edge 6).
  - Minimum accepted pulse width is DEBOUNCE cycles after synchronisation.
- Position:
  - outputs and pos_valid update at edge STAGES + 1 + STABLE (default: edge 6).
  - The input must hold for STABLE + 1 cycles past synchronisation to commit.
- Pulses last exactly one cycle. A level change re-arms a pulse only after a new filter run.
- There is no back-pressure. pos_valid is informational, and consumers sample it on the pulse.

## Structure
- Shared package `input_sync_pkg`: default values for CHANNELS, STAGES, DEBOUNCE, POS_W and STABLE; index localparams BTN_LEFT = 0, BTN_RIGHT = 1, BTN_MIDDLE = 2.
- Sub-module `btn_debounce`: one channel containing its sync chain, counter and edge pulses, with parameters STAGES and DEBOUNCE. It is instantiated CHANNELS times in a generate loop.
- The position path is coded inline in the top module.
- Elaboration-time assertions enforce STAGES ≥ 2, DEBOUNCE ≥ 1 and STABLE ≥ 1.

## Test plan
- Reset: drive btn_in = 3'b111 and xpos_in = 12'd500 while rst = 0 for 5 cycles → all outputs 0 and no pulses. After rst = 1, btn_out = 3'b111 with btn_rise = 3'b111 at edge 6, and xpos_out = 500 with pos_valid at edge 6.
- Button glitch: left high for 3 cycles, then low → btn_out[0] stays 0 and btn_rise[0] never fires. Held for 4 cycles → btn_rise[0] fires once, at edge 6.
- Release: right falls after being high → btn_fall[1] fires for one cycle at edge 6. Middle toggles in the same cycle → both pulses coincide.
- Skewed bus: xpos_in steps 100→103 through intermediate values 101 and 102, one cycle each → a single commit of 103 and exactly one pos_valid.
- Revisit: committed (200, 300), then ypos_in = 301 for 2 cycles, then back to 300 → no pos_valid and the outputs stay at (200, 300).
- Mid-filter reset: xpos_in changes, then rst = 0 at edge 4 for 1 cycle → no pos_valid during reset and outputs are 0. The commit restarts with the full latency after release.
